inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/core_pkg.sv | 7 +
 rtl/iq_compact.sv | 25 ++
 rtl/inst_queue.sv | 97 +++++++++
 tb/tb_inst_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core constants and types: instruction width, issue width, instruction type.
package core_pkg;
    localparam int IW      = 32;
    localparam int ISSUE_W = 3;

    typedef logic [IW-1:0] inst_t;
endpackage

// File: rtl/iq_compact.sv
// Packs the valid fetch lanes (x,y,z order) into the low slots and reports how many there are.
module iq_compact
    import core_pkg::*;
#(
    parameter int LW = core_pkg::IW
) (
    input  logic [ISSUE_W-1:0]    valid,
    input  logic [ISSUE_W*LW-1:0] inst,
    output logic [ISSUE_W*LW-1:0] packed_inst,
    output logic [1:0]            num
);
    int slot;

    always_comb begin
        packed_inst = '0;
        slot        = 0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (valid[k]) begin
                packed_inst[slot*LW +: LW] = inst[k*LW +: LW];
                slot                       = slot + 1;
            end
        end
        num = 2'(slot);
    end
endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch (3 lanes in) and decode (3 lanes out).
// Define INST_QUEUE_PERF_EN to add the saturating stall_cnt output.
module inst_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IW    = core_pkg::IW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [2:0]                    in_valid,
    input  logic [3*IW-1:0]               in_inst,
    output logic                          in_ready,
    output logic [2:0]                    out_valid,
    output logic [3*IW-1:0]               out_inst,
    input  logic                          pop,
`ifdef INST_QUEUE_PERF_EN
    output logic [31:0]                   stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]        count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0]      mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count_q;
    logic [3*IW-1:0]    packed_inst;
    logic [1:0]         in_num;
    logic [1:0]         push_n;
    logic [1:0]         pop_m;
    logic [CW-1:0]      count_next;

    iq_compact #(.LW(IW)) u_compact (
        .valid       (in_valid),
        .inst        (in_inst),
        .packed_inst (packed_inst),
        .num         (in_num)
    );

    // Acceptance is based on current occupancy only; a same-cycle pop earns no credit.
    assign in_ready   = (count_q <= CW'(DEPTH - 3));
    assign push_n     = in_ready ? in_num : 2'd0;
    assign pop_m      = !pop ? 2'd0 : ((count_q >= CW'(3)) ? 2'd3 : count_q[1:0]);
    assign count_next = count_q + CW'(push_n) - CW'(pop_m);
    assign count      = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PW'(pop_m);
            tail    <= tail + PW'(push_n);
            count_q <= count_next;
        end
    end

    // Storage is deliberately left unreset; output masking hides stale entries.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (k < int'(push_n)) begin
                    mem[tail + PW'(k)] <= packed_inst[k*IW +: IW];
                end
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            out_valid[k] = (count_q > CW'(k));
            if (out_valid[k]) begin
                out_inst[k*IW +: IW] = mem[head + PW'(k)];
            end
        end
    end

`ifdef INST_QUEUE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((|in_valid) && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH=8, IW=32) against a queue-based reference model.
module tb_inst_queue;
    import core_pkg::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  in_valid;
    logic [95:0] in_inst;
    logic        in_ready;
    logic [2:0]  out_valid;
    logic [95:0] out_inst;
    logic        pop;
    logic [3:0]  count;
`ifdef INST_QUEUE_PERF_EN
    logic [31:0] stall_cnt;
`endif

    inst_queue #(.DEPTH(DEPTH), .IW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .pop       (pop),
`ifdef INST_QUEUE_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .count     (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    inst_t       exp_q[$];
    int unsigned exp_stall;
    int          n_checks;
    int          n_pass;

    function automatic logic [2:0] exp_valid();
        logic [2:0] v;
        v = '0;
        for (int k = 0; k < 3; k++) v[k] = (k < exp_q.size());
        return v;
    endfunction

    function automatic logic [95:0] exp_inst();
        logic [95:0] d;
        d = '0;
        for (int k = 0; k < 3; k++) if (k < exp_q.size()) d[k*32 +: 32] = exp_q[k];
        return d;
    endfunction

    function automatic logic exp_ready();
        return exp_q.size() <= DEPTH - 3;
    endfunction

    // ---------------- driver ----------------
    // One clock: apply inputs, advance the model by the same rules, sample 1 time unit after the edge.
    task automatic drive(input logic [2:0] v, input logic [95:0] d, input logic p, input logic f);
        int m;
        logic rdy;
        @(negedge clk);
        in_valid = v;
        in_inst  = d;
        pop      = p;
        flush    = f;
        rdy      = exp_ready();
        if ((|v) && !rdy) exp_stall++;
        if (f) begin
            exp_q.delete();
        end else begin
            m = p ? ((exp_q.size() < 3) ? exp_q.size() : 3) : 0;
            repeat (m) void'(exp_q.pop_front());
            if (rdy) for (int k = 0; k < 3; k++) if (v[k]) exp_q.push_back(d[k*32 +: 32]);
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        pop      = 1'b0;
        flush    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; flush = 0; in_valid = 0; in_inst = 0; pop = 0;
        exp_q.delete();
        exp_stall = 0;
        #2;
        n_checks++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (out_valid !== 3'b000) $display("FAIL reset_out_valid got=%b exp=000", out_valid); else n_pass++;
        n_checks++; if (out_inst !== 96'd0) $display("FAIL reset_out_inst got=%h exp=0", out_inst); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (count !== 4'd0) $display("FAIL post_reset_count got=%0d exp=0", count); else n_pass++;
    endtask

    task automatic test_full_group();
        drive(3'b111, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd3) $display("FAIL group_count got=%0d exp=3", count); else n_pass++;
        n_checks++; if (out_valid !== 3'b111) $display("FAIL group_valid got=%b exp=111", out_valid); else n_pass++;
        n_checks++;
        if (out_inst !== {32'h33, 32'h22, 32'h11}) $display("FAIL group_inst got=%h exp=%h", out_inst, {32'h33, 32'h22, 32'h11});
        else n_pass++;
        drive(3'b000, '0, 1'b0, 1'b1);
    endtask

    task automatic test_compact();
        drive(3'b101, {32'hA3, 32'hDEAD_BEEF, 32'hA1}, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd2) $display("FAIL compact_count got=%0d exp=2", count); else n_pass++;
        n_checks++; if (out_valid !== 3'b011) $display("FAIL compact_valid got=%b exp=011", out_valid); else n_pass++;
        n_checks++; if (out_inst[31:0] !== 32'hA1) $display("FAIL compact_lane_x got=%h exp=a1", out_inst[31:0]); else n_pass++;
        n_checks++; if (out_inst[63:32] !== 32'hA3) $display("FAIL compact_lane_y got=%h exp=a3", out_inst[63:32]); else n_pass++;
        n_checks++; if (out_inst[95:64] !== 32'h0) $display("FAIL compact_lane_z got=%h exp=0", out_inst[95:64]); else n_pass++;
        drive(3'b000, '0, 1'b0, 1'b1);
    endtask

    task automatic test_full();
        int unsigned stall0;
        drive(3'b111, {32'h103, 32'h102, 32'h101}, 1'b0, 1'b0);
        drive(3'b111, {32'h106, 32'h105, 32'h104}, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd6) $display("FAIL full_count got=%0d exp=6", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", in_ready); else n_pass++;
        stall0 = exp_stall;
`ifdef INST_QUEUE_PERF_EN
        n_checks++; if (stall_cnt !== 32'(stall0)) $display("FAIL stall_before got=%0d exp=%0d", stall_cnt, stall0); else n_pass++;
`endif
        drive(3'b111, {32'h1FF, 32'h1FF, 32'h1FF}, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd6) $display("FAIL full_drop_count got=%0d exp=6", count); else n_pass++;
`ifdef INST_QUEUE_PERF_EN
        n_checks++; if (stall_cnt !== 32'(stall0 + 1)) $display("FAIL stall_incr got=%0d exp=%0d", stall_cnt, stall0 + 1); else n_pass++;
`endif
        drive(3'b000, '0, 1'b1, 1'b0);
        n_checks++; if (count !== 4'd3) $display("FAIL full_pop_count got=%0d exp=3", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL full_pop_ready got=%b exp=1", in_ready); else n_pass++;
        n_checks++; if (out_inst !== exp_inst()) $display("FAIL full_pop_inst got=%h exp=%h", out_inst, exp_inst()); else n_pass++;
        drive(3'b000, '0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [95:0] d;
        drive(3'b111, {32'hC3, 32'hC2, 32'hC1}, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            d = {$urandom(), $urandom(), $urandom()};
            drive(3'b111, d, 1'b1, 1'b0);
            n_checks++; if (count !== 4'd3) $display("FAIL b2b_count[%0d] got=%0d exp=3", i, count); else n_pass++;
            n_checks++;
            if (out_inst !== d) $display("FAIL b2b_order[%0d] got=%h exp=%h", i, out_inst, d);
            else n_pass++;
        end
        drive(3'b000, '0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        drive(3'b111, {32'hE3, 32'hE2, 32'hE1}, 1'b0, 1'b0);
        drive(3'b101, {32'hE5, 32'h0, 32'hE4}, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd5) $display("FAIL flush_pre_count got=%0d exp=5", count); else n_pass++;
        drive(3'b111, {32'hF3, 32'hF2, 32'hF1}, 1'b1, 1'b1);
        n_checks++; if (count !== 4'd0) $display("FAIL flush_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (out_valid !== 3'b000) $display("FAIL flush_valid got=%b exp=000", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0]  v;
        logic [95:0] d;
        logic        p;
        logic        f;
        for (int i = 0; i < 300; i++) begin
            v = 3'($urandom_range(0, 7));
            d = {$urandom(), $urandom(), $urandom()};
            p = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 40) == 0);
            drive(v, d, p, f);
            n_checks++;
            if (count !== 4'(exp_q.size())) $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, count, exp_q.size());
            else n_pass++;
            n_checks++;
            if (in_ready !== exp_ready()) $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready());
            else n_pass++;
            n_checks++;
            if (out_valid !== exp_valid()) $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, exp_valid());
            else n_pass++;
            n_checks++;
            if (out_inst !== exp_inst()) $display("FAIL rand_inst[%0d] got=%h exp=%h", i, out_inst, exp_inst());
            else n_pass++;
        end
`ifdef INST_QUEUE_PERF_EN
        n_checks++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL rand_stall got=%0d exp=%0d", stall_cnt, exp_stall); else n_pass++;
`endif
        drive(3'b000, '0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        drive(3'b111, {32'hB3, 32'hB2, 32'hB1}, 1'b0, 1'b0);
        drive(3'b001, {32'h0, 32'h0, 32'hB4}, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd4) $display("FAIL areset_pre_count got=%0d exp=4", count); else n_pass++;
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        n_checks++; if (count !== 4'd0) $display("FAIL areset_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (out_valid !== 3'b000) $display("FAIL areset_valid got=%b exp=000", out_valid); else n_pass++;
        n_checks++; if (out_inst !== 96'd0) $display("FAIL areset_inst got=%h exp=0", out_inst); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        drive(3'b010, {32'h0, 32'h77, 32'h0}, 1'b0, 1'b0);
        n_checks++; if (out_inst !== 96'h77) $display("FAIL areset_resume got=%h exp=77", out_inst); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_full_group();
        test_compact();
        test_full();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
